hex_display_mux: RTL and testbench
==================================

HEX_DISPLAY_MUX -- requirements
Module: hex_display_mux

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, number of multiplexed hex digits; legal range 1..8.
REQ-002 The block SHALL have parameter DIV, default 50000, clocks per digit slot; legal minimum 2.
REQ-003 The block SHALL have port clk, input, 1 bit, single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, reset, synchronous and active-high.
REQ-005 The block SHALL have port load, input, 1 bit, captures value/dp into the shadow register.
REQ-006 The block SHALL have port value, input, 4*N_DIGITS bits, hex digits; nibble i drives digit i, with digit 0 = value[3:0].
REQ-007 The block SHALL have port dp, input, N_DIGITS bits, decimal point request per digit, captured with load.
REQ-008 The block SHALL have port dig_en, input, N_DIGITS bits, live per-digit enable, not latched.
REQ-009 The block SHALL have port seg, output, 7 bits, active-low segments {a,b,c,d,e,f,g}, with a = bit 6 and g = bit 0.
REQ-010 The block SHALL have port dp_n, output, 1 bit, active-low decimal point.
REQ-011 The block SHALL have port an, output, N_DIGITS bits, active-low digit select, at most one bit low.
REQ-012 The block SHALL have port scan_idx, output, clog2(N_DIGITS) bits (min 1), current slot index.

Function
REQ-013 Segment codes 0..F SHALL be: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000.
REQ-014 Prescaler cnt SHALL count 0..DIV-1 and wrap to 0; tick SHALL equal (cnt == DIV-1).
REQ-015 On tick, idx SHALL advance by 1 and wrap from N_DIGITS-1 to 0; otherwise idx SHALL hold.
REQ-016 scan_idx SHALL equal idx.
REQ-017 When load=1 at an edge, value_q<=value and dp_q<=dp.
REQ-018 seg, an and dp_n SHALL be registered every clock from pre-edge idx, value_q, dp_q and dig_en, giving one-cycle latency.
REQ-019 When the slot is active: an[idx]=0, other an bits 1, seg = code(value_q nibble idx), dp_n = ~dp_q[idx].
REQ-020 When the slot is disabled (dig_en[idx]=0) or blanked: an all 1, seg=1111111, dp_n=1; the slot time SHALL still be consumed.
REQ-021 Simultaneous load and tick SHALL both take effect at the same edge; output registered at that edge SHALL use the old idx and old value_q.
REQ-022 A load mid-slot SHALL change seg on the following clock if its nibble is the active digit; cnt and idx SHALL be unaffected.
REQ-023 N_DIGITS=1: idx SHALL stay 0; an[0] SHALL be driven solely by dig_en[0] and blanking.

Reset
REQ-024 With rst=1 at an edge: cnt=0, idx=0, value_q=0, dp_q=0, seg=1111111, an=all 1, dp_n=1; rst SHALL override load and tick.
REQ-025 Reset deasserted SHALL start scanning at slot 0, with first tick DIV clocks after the first non-reset edge.

Configuration
REQ-026 Macro HEX_DISPLAY_LZB_EN defined: digit i>0 SHALL be blanked when value_q nibbles i..N_DIGITS-1 are all zero; digit 0 SHALL never be blanked by this rule.
REQ-027 Macro HEX_DISPLAY_LZB_EN undefined: no leading-zero blanking SHALL occur; zeros SHALL display as 0000001.

Verification (N_DIGITS=4, DIV=4)
REQ-028 Reset check: rst=1 for 3 clocks -> seg=1111111, an=1111, dp_n=1, scan_idx=0.
REQ-029 Scan check: load value=16'h12AF, dp=4'b0100, dig_en=1111 -> 4-clock slots, an 1110/1101/1011/0111, seg 0111000/0001000/0010010/1001111, dp_n low only in slot 2.
REQ-030 Wrap and period check: an SHALL return to 1110 exactly 16 clocks after its previous 1110 onset.
REQ-031 Enable check: dig_en=1011 -> slot 2 gives an=1111, seg=1111111; slots 0, 1 and 3 SHALL be unchanged.
REQ-032 Blanking check: load 16'h0005 -> with macro, slots 1-3 blank and slot 0 seg=0100100; without macro, slots 1-3 seg=0000001; load 16'h0000 with macro -> slot 0 shows 0000001.
REQ-033 Collision and reset check: load 16'hFFFF on the tick edge of slot 1 -> next slot-2 output = 0111000; rst mid-slot 2 -> next clock shows reset values and scanning resumes at slot 0.

Source files
------------

// File: rtl/hex_display_mux.sv
// Multiplexed hex seven-segment driver: scans N_DIGITS digits, DIV clocks per slot.
// Define HEX_DISPLAY_LZB_EN to blank leading zero digits (digit 0 is always shown).
module hex_display_mux #(
  parameter int N_DIGITS = 4,
  parameter int DIV      = 50000,
  localparam int IW      = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1,
  localparam int CW      = $clog2(DIV)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   dig_en,
  output logic [6:0]            seg,
  output logic                  dp_n,
  output logic [N_DIGITS-1:0]   an,
  output logic [IW-1:0]         scan_idx
);

  logic [CW-1:0]              cnt;
  logic [IW-1:0]              idx;
  logic [N_DIGITS-1:0][3:0]   value_q;
  logic [N_DIGITS-1:0]        dp_q;
  logic [N_DIGITS-1:0]        blank;
  logic                       tick;
  logic [3:0]                 sel_nib;
  logic                       sel_dp, sel_en, sel_blank, sel_on;

  // Active-low segments {a,b,c,d,e,f,g}
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign tick     = (cnt == CW'(DIV - 1));
  assign scan_idx = idx;

  // Digit i>0 blanks when it and every higher nibble are zero.
  always_comb begin
    blank = '0;
`ifdef HEX_DISPLAY_LZB_EN
    begin
      logic zero_run;
      zero_run = 1'b1;
      for (int i = N_DIGITS - 1; i > 0; i--) begin
        zero_run = zero_run & (value_q[i] == 4'h0);
        blank[i] = zero_run;
      end
    end
`endif
  end

  always_comb begin
    sel_nib   = 4'h0;
    sel_dp    = 1'b0;
    sel_en    = 1'b0;
    sel_blank = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        sel_nib   = value_q[i];
        sel_dp    = dp_q[i];
        sel_en    = dig_en[i];
        sel_blank = blank[i];
      end
    end
    sel_on = sel_en & ~sel_blank;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      value_q <= '0;
      dp_q    <= '0;
      seg     <= 7'b1111111;
      an      <= '1;
      dp_n    <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick)
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (load) begin
        value_q <= value;
        dp_q    <= dp;
      end
      // Outputs use pre-edge idx/value_q, so a colliding load or tick shows next cycle.
      seg  <= sel_on ? hex7(sel_nib) : 7'b1111111;
      an   <= sel_on ? ~(N_DIGITS'(1) << idx) : '1;
      dp_n <= sel_on ? ~sel_dp : 1'b1;
    end
  end

endmodule

// File: tb/tb_hex_display_mux.sv
// Directed bench for hex_display_mux at N_DIGITS=4, DIV=4.
module tb_hex_display_mux;
  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] value;
  logic [3:0]  dp, dig_en;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an;
  logic [1:0]  scan_idx;

  int checks = 0;
  int errors = 0;

`ifdef HEX_DISPLAY_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  hex_display_mux #(.N_DIGITS(4), .DIV(4)) dut (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp), .dig_en(dig_en),
    .seg(seg), .dp_n(dp_n), .an(an), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic [6:0] s, input logic [3:0] a, input logic d);
    chk({name, ".seg"}, 32'(seg), 32'(s));
    chk({name, ".an"}, 32'(an), 32'(a));
    chk({name, ".dp_n"}, 32'(dp_n), 32'(d));
  endtask

  typedef struct {
    int         ncyc;
    logic [3:0] en;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dpn;
    logic [1:0] sidx;
  } vec_t;

  vec_t vt[8];
  logic [6:0] z_seg;
  logic [3:0] z_an;

  initial begin
    // value 12AF, dp 0100: slot k output is sampled at its last clock
    vt[0] = '{3, 4'b1111, 7'b0111000, 4'b1110, 1'b1, 2'd1};
    vt[1] = '{4, 4'b1111, 7'b0001000, 4'b1101, 1'b1, 2'd2};
    vt[2] = '{4, 4'b1111, 7'b0010010, 4'b1011, 1'b0, 2'd3};
    vt[3] = '{4, 4'b1111, 7'b1001111, 4'b0111, 1'b1, 2'd0};
    vt[4] = '{4, 4'b1111, 7'b0111000, 4'b1110, 1'b1, 2'd1};
    vt[5] = '{4, 4'b1011, 7'b0001000, 4'b1101, 1'b1, 2'd2};
    vt[6] = '{4, 4'b1011, 7'b1111111, 4'b1111, 1'b1, 2'd3};
    vt[7] = '{4, 4'b1011, 7'b1001111, 4'b0111, 1'b1, 2'd0};

    rst = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0; dig_en = 4'b1111;
    step(3);
    chk_out("reset", 7'b1111111, 4'b1111, 1'b1);
    chk("reset.scan_idx", 32'(scan_idx), 32'd0);

    // Load on the first non-reset edge; that edge still displays the old zero.
    rst = 1'b0; load = 1'b1; value = 16'h12AF; dp = 4'b0100;
    step(1);
    load = 1'b0;
    chk_out("first", 7'b0000001, 4'b1110, 1'b1);
    chk("first.scan_idx", 32'(scan_idx), 32'd0);

    for (int i = 0; i < 8; i++) begin
      dig_en = vt[i].en;
      step(vt[i].ncyc);
      chk_out($sformatf("vec%0d", i), vt[i].seg, vt[i].an, vt[i].dpn);
      chk($sformatf("vec%0d.scan_idx", i), 32'(scan_idx), 32'(vt[i].sidx));
    end

    // Period: slot 0 onset recurs every 16 clocks.
    dig_en = 4'b1111;
    step(1);
    chk("period.onset", 32'(an), 32'b1110);
    step(15);
    chk("period.before", 32'(an), 32'b0111);
    step(1);
    chk("period.again", 32'(an), 32'b1110);

    // Leading-zero blanking with value 0005.
    load = 1'b1; value = 16'h0005; dp = 4'h0;
    step(1);
    load = 1'b0;
    step(2);
    chk_out("lzb.slot0", 7'b0100100, 4'b1110, 1'b1);
    z_seg = LZB ? 7'b1111111 : 7'b0000001;
    for (int k = 1; k < 4; k++) begin
      z_an = LZB ? 4'b1111 : ~(4'b0001 << k);
      step(4);
      chk_out($sformatf("lzb.slot%0d", k), z_seg, z_an, 1'b1);
    end

    // Mid-slot load of 0000 in slot 0: seg follows one clock later; slot timing untouched.
    load = 1'b1; value = 16'h0000;
    step(1);
    load = 1'b0;
    chk("midload.old", 32'(seg), 32'(7'b0100100));
    step(1);
    chk_out("midload.new", 7'b0000001, 4'b1110, 1'b1);
    step(1);
    chk("midload.idx_hold", 32'(scan_idx), 32'd0);
    step(1);
    chk("midload.idx_adv", 32'(scan_idx), 32'd1);

    // Load FFFF on the slot-1 tick edge: that edge shows old slot 1 of 0000.
    step(3);
    load = 1'b1; value = 16'hFFFF;
    step(1);
    load = 1'b0;
    chk_out("collide.old", z_seg, LZB ? 4'b1111 : 4'b1101, 1'b1);
    chk("collide.scan_idx", 32'(scan_idx), 32'd2);
    step(1);
    chk_out("collide.slot2", 7'b0111000, 4'b1011, 1'b1);

    // Reset mid-slot 2, overriding a pending load.
    step(1);
    rst = 1'b1; load = 1'b1; value = 16'h1234;
    step(1);
    rst = 1'b0; load = 1'b0;
    chk_out("midrst", 7'b1111111, 4'b1111, 1'b1);
    chk("midrst.scan_idx", 32'(scan_idx), 32'd0);
    step(1);
    chk_out("resume", 7'b0000001, 4'b1110, 1'b1);
    step(2);
    chk("resume.idx_hold", 32'(scan_idx), 32'd0);
    step(1);
    chk("resume.first_tick", 32'(scan_idx), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
